lfsr_2: RTL and testbench

LFSR_2 -- requirements
Module: lfsr_2

---
 rtl/lfsr_2_pkg.sv | 12 +
 rtl/lfsr_2.sv | 92 +++++++++
 tb/tb_lfsr_2.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_2_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_2_pkg
// Shared constants for the lfsr_2 block: default register width and the
// default feedback tap mask (x^8+x^6+x^5+x^4+1, taps on bits 7,5,4,3).
// No ports; imported by lfsr_2.
// ----------------------------------------------------------------------------
package lfsr_2_pkg;

   localparam int         LFSR_WIDTH = 32'd8;
   localparam logic [7:0] LFSR_TAPS  = 8'hB8;

endpackage : lfsr_2_pkg

// File: rtl/lfsr_2.sv
// ----------------------------------------------------------------------------
// lfsr_2
// Fibonacci LFSR with a seed captured on the first clock after reset
// release. The state shifts toward the MSB and the feedback bit enters at
// the LSB. wrap pulses for one cycle after a step lands back on the seed.
//
// Ports
//   clk    : in  1      sole clock, rising edge
//   rst    : in  1      asynchronous reset, active low
//   init   : in  WIDTH  seed, sampled once on the first edge after reset
//   shift  : in  1      advance one step per rising edge while high
//   result : out WIDTH  current LFSR state (straight from the register)
//   wrap   : out 1      registered pulse: last step returned to the seed
// ----------------------------------------------------------------------------
module lfsr_2
   import lfsr_2_pkg::*;
#(
   parameter int               WIDTH = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] init,
   input  logic             shift,
   output logic [WIDTH-1:0] result,
   output logic             wrap
);

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] seed_r;
   logic             loaded_r;
   logic             wrap_r;

   logic             fb_s;
   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] load_val_s;
   logic [WIDTH-1:0] state_d_s;
   logic [WIDTH-1:0] seed_d_s;
   logic             loaded_d_s;
   logic             wrap_d_s;

   // Feedback, stepped value and guarded seed value.
   always_comb begin
      fb_s   = ^(state_r & TAPS);
      step_s = {state_r[WIDTH-2:0], fb_s};
      // An all-zero seed would lock the register at zero forever, so it is
      // replaced by 1.
      if (init == {WIDTH{1'b0}}) begin
         load_val_s = {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         load_val_s = init;
      end
   end

   // Next-state selection: load once, then step or hold.
   always_comb begin
      state_d_s  = state_r;
      seed_d_s   = seed_r;
      loaded_d_s = loaded_r;
      wrap_d_s   = 1'b0;
      if (!loaded_r) begin
         // The load edge takes priority over shift; stepping starts next edge.
         state_d_s  = load_val_s;
         seed_d_s   = load_val_s;
         loaded_d_s = 1'b1;
      end else if (shift) begin
         state_d_s = step_s;
         wrap_d_s  = (step_s == seed_r);
      end else begin
         state_d_s = state_r;
      end
   end

   // State, seed, loaded flag and wrap pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= {WIDTH{1'b0}};
         seed_r   <= {WIDTH{1'b0}};
         loaded_r <= 1'b0;
         wrap_r   <= 1'b0;
      end else begin
         state_r  <= state_d_s;
         seed_r   <= seed_d_s;
         loaded_r <= loaded_d_s;
         wrap_r   <= wrap_d_s;
      end
   end

   assign result = state_r;
   assign wrap   = wrap_r;

endmodule : lfsr_2

// File: tb/tb_lfsr_2.sv
// ----------------------------------------------------------------------------
// tb_lfsr_2
// Directed, self-checking bench for lfsr_2 with default parameters. Expected
// result/wrap values come from a bench-side LFSR model and are queued when a
// step is driven, then popped and compared after the clock edge.
// ----------------------------------------------------------------------------
module tb_lfsr_2;

   logic       clk;
   logic       rst;
   logic [7:0] init;
   logic       shift;
   logic [7:0] result;
   logic       wrap;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] q_res[$];
   logic       q_wrap[$];

   logic [7:0] m_state;
   logic [7:0] m_seed;
   logic       m_loaded;

   lfsr_2 dut (
      .clk    (clk),
      .rst    (rst),
      .init   (init),
      .shift  (shift),
      .result (result),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference step: x^8+x^6+x^5+x^4+1, taps on bits 7,5,4,3.
   function automatic logic [7:0] model_next(input logic [7:0] s);
      logic fb;
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      return {s[6:0], fb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state  = 8'h00;
      m_seed   = 8'h00;
      m_loaded = 1'b0;
   endtask

   // Drive one cycle with the given shift, queue the expectation, compare.
   task automatic step(input logic sh, input string tag);
      logic       exp_w;
      logic [7:0] e_res;
      logic       e_wrap;
      shift = sh;
      exp_w = 1'b0;
      if (!m_loaded) begin
         m_state  = (init == 8'h00) ? 8'h01 : init;
         m_seed   = m_state;
         m_loaded = 1'b1;
      end else if (sh) begin
         m_state = model_next(m_state);
         exp_w   = (m_state == m_seed);
      end
      q_res.push_back(m_state);
      q_wrap.push_back(exp_w);
      @(posedge clk);
      #1;
      e_res  = q_res.pop_front();
      e_wrap = q_wrap.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e_res));
      check({tag, "_wrap"}, 32'(wrap), 32'(e_wrap));
   endtask

   initial begin
      int wraps;
      int seed_hits;
      int zero_hits;

      rst   = 1'b0;
      shift = 1'b0;
      init  = 8'h00;
      model_reset();
      #3;
      check("reset_result", 32'(result), 32'h0);
      check("reset_wrap", 32'(wrap), 32'h0);

      // Seed load with shift low, then hold.
      @(posedge clk);
      #1;
      init = 8'h05;
      rst  = 1'b1;
      step(1'b0, "load05");
      step(1'b0, "hold05");

      // First three steps from seed 0x05.
      check("seq_ref0", 32'(model_next(8'h05)), 32'h0A);
      step(1'b1, "seq1");
      check("seq1_known", 32'(result), 32'h0A);
      step(1'b1, "seq2");
      check("seq2_known", 32'(result), 32'h15);
      step(1'b1, "seq3");
      check("seq3_known", 32'(result), 32'h2B);

      // Full period from a fresh 0x05 load; shift high during the load edge.
      rst = 1'b0;
      model_reset();
      #2;
      rst  = 1'b1;
      init = 8'h05;
      step(1'b1, "reload05");
      wraps     = 0;
      seed_hits = 0;
      zero_hits = 0;
      for (int i = 1; i <= 255; i++) begin
         step(1'b1, "period");
         if (wrap) wraps++;
         if (i < 255 && result == 8'h05) seed_hits++;
         if (result == 8'h00) zero_hits++;
      end
      check("period_end", 32'(result), 32'h05);
      check("period_wraps", 32'(wraps), 32'd1);
      check("period_seed_hits", 32'(seed_hits), 32'd0);
      check("period_zero_hits", 32'(zero_hits), 32'd0);
      step(1'b1, "post_wrap");
      check("post_wrap_low", 32'(wrap), 32'h0);

      // Zero seed guard.
      rst = 1'b0;
      model_reset();
      #2;
      rst  = 1'b1;
      init = 8'h00;
      step(1'b0, "zero_load");
      check("zero_load_known", 32'(result), 32'h01);
      step(1'b1, "zero_step");
      check("zero_step_known", 32'(result), 32'h02);

      // Alternating shift, with init disturbed after loading.
      init = 8'hFF;
      for (int i = 0; i < 12; i++) begin
         step(1'(i % 2), "toggle");
      end

      // Asynchronous reset between edges aborts immediately.
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_rst_result", 32'(result), 32'h0);
      check("async_rst_wrap", 32'(wrap), 32'h0);
      init = 8'hA5;
      #1;
      rst = 1'b1;
      check("rst_release_nochange", 32'(result), 32'h0);
      step(1'b0, "reloadA5");
      check("reloadA5_known", 32'(result), 32'hA5);
      step(1'b1, "A5_step");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_lfsr_2
